eth_axis_tx_arb: RTL

- Per-frame round-robin arbiter that merges N_CH independent 8-bit AXI-Stream transmit sources into the single tx_axis stream of the 1G RGMII MAC.
- Sits between the host-side DMA/packet engines and the MAC TX FIFO, in the MAC logic clock domain.
- Successor to the single-source TX path: it adds multi-channel arbitration, whole-frame grant hold, short-frame padding and per-channel status.

---
 rtl/eth_axis_tx_arb.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/eth_axis_tx_arb.sv
// eth_axis_tx_arb: per-frame round-robin merge of N_CH byte-wide AXI-Stream TX sources onto the MAC tx_axis.
// Optional macro ETH_TX_ARB_PAD_EN adds zero padding of short frames up to MIN_FRAME_LENGTH-4 bytes.

module eth_axis_tx_arb #(
    parameter int N_CH             = 2,
    parameter int MIN_FRAME_LENGTH = 64,
    parameter int CNT_WIDTH        = 16,
    localparam int GW              = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_CH*8-1:0]         s_axis_tdata,
    input  logic [N_CH-1:0]           s_axis_tvalid,
    input  logic [N_CH-1:0]           s_axis_tlast,
    input  logic [N_CH-1:0]           s_axis_tuser,
    output logic [N_CH-1:0]           s_axis_tready,
    output logic [7:0]                m_axis_tdata,
    output logic                      m_axis_tvalid,
    input  logic                      m_axis_tready,
    output logic                      m_axis_tlast,
    output logic                      m_axis_tuser,
    output logic [GW-1:0]             grant,
    output logic                      busy,
    output logic [N_CH-1:0]           frame_done,
    output logic [N_CH*CNT_WIDTH-1:0] frame_cnt
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PASS = 2'd1;

    logic [1:0]           state_q, state_d;
    logic [GW-1:0]        grant_q, grant_d;
    logic [GW-1:0]        ptr_q, ptr_d;
    logic [N_CH-1:0]      done_q, done_d;
    logic [CNT_WIDTH-1:0] cnt_q [N_CH];

    logic          any_req;
    logic [GW-1:0] rr_sel;
    logic [7:0]    g_data;
    logic          g_valid, g_last, g_user;
    logic          long_enough;

`ifdef ETH_TX_ARB_PAD_EN
    localparam logic [1:0] ST_PAD = 2'd2;
    localparam int         BCW    = $clog2(MIN_FRAME_LENGTH) + 1;
    localparam logic [BCW-1:0] PAD_TARGET = BCW'(MIN_FRAME_LENGTH - 4);

    logic [BCW-1:0] bcnt_q, bcnt_d, bcnt_inc;
    logic           tuser_q, tuser_d;

    // Count including the beat currently offered; saturates so long frames never wrap back below target.
    assign bcnt_inc    = (bcnt_q == '1) ? bcnt_q : bcnt_q + 1'b1;
    assign long_enough = (bcnt_inc >= PAD_TARGET);
`else
    assign long_enough = 1'b1;
`endif

    // Rotating search starting just past the last granted channel.
    always_comb begin
        rr_sel  = ptr_q;
        any_req = 1'b0;
        for (int k = 1; k <= N_CH; k++) begin
            if (!any_req && s_axis_tvalid[(int'(ptr_q) + k) % N_CH]) begin
                rr_sel  = GW'((int'(ptr_q) + k) % N_CH);
                any_req = 1'b1;
            end
        end
    end

    assign g_data  = s_axis_tdata[int'(grant_q)*8 +: 8];
    assign g_valid = s_axis_tvalid[grant_q];
    assign g_last  = s_axis_tlast[grant_q];
    assign g_user  = s_axis_tuser[grant_q];

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        ptr_d         = ptr_q;
        done_d        = '0;
        m_axis_tdata  = 8'h00;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        m_axis_tuser  = 1'b0;
        s_axis_tready = '0;
`ifdef ETH_TX_ARB_PAD_EN
        bcnt_d        = bcnt_q;
        tuser_d       = tuser_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    state_d = ST_PASS;
                    grant_d = rr_sel;
                    ptr_d   = rr_sel;
`ifdef ETH_TX_ARB_PAD_EN
                    bcnt_d  = '0;
`endif
                end
            end
            ST_PASS: begin
                m_axis_tdata           = g_data;
                m_axis_tvalid          = g_valid;
                m_axis_tlast           = g_valid & g_last & long_enough;
                m_axis_tuser           = m_axis_tlast & g_user;
                s_axis_tready[grant_q] = m_axis_tready;
                if (g_valid && m_axis_tready) begin
`ifdef ETH_TX_ARB_PAD_EN
                    bcnt_d = bcnt_inc;
`endif
                    if (g_last) begin
                        if (long_enough) begin
                            done_d[grant_q] = 1'b1;
                            state_d         = ST_IDLE;
                        end else begin
`ifdef ETH_TX_ARB_PAD_EN
                            tuser_d = g_user;
                            state_d = ST_PAD;
`endif
                        end
                    end
                end
            end
`ifdef ETH_TX_ARB_PAD_EN
            ST_PAD: begin
                m_axis_tvalid = 1'b1;
                m_axis_tlast  = (bcnt_inc >= PAD_TARGET);
                m_axis_tuser  = m_axis_tlast & tuser_q;
                if (m_axis_tready) begin
                    bcnt_d = bcnt_inc;
                    if (m_axis_tlast) begin
                        done_d[grant_q] = 1'b1;
                        state_d         = ST_IDLE;
                    end
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            ptr_q   <= GW'(N_CH - 1);
            done_q  <= '0;
            for (int i = 0; i < N_CH; i++) cnt_q[i] <= '0;
`ifdef ETH_TX_ARB_PAD_EN
            bcnt_q  <= '0;
            tuser_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            done_q  <= done_d;
            for (int i = 0; i < N_CH; i++) begin
                if (done_d[i]) cnt_q[i] <= cnt_q[i] + 1'b1;
            end
`ifdef ETH_TX_ARB_PAD_EN
            bcnt_q  <= bcnt_d;
            tuser_q <= tuser_d;
`endif
        end
    end

    assign grant      = grant_q;
    assign busy       = (state_q != ST_IDLE);
    assign frame_done = done_q;

    for (genvar i = 0; i < N_CH; i++) begin : g_cnt
        assign frame_cnt[i*CNT_WIDTH +: CNT_WIDTH] = cnt_q[i];
    end

endmodule
